// File: rtl/axi_wr_arb_pkg.sv
// Shared state encoding, payload widths and field offsets for the two-master AXI write arbiter.
package axi_wr_arb_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   localparam int AWINFO_W  = 45;
   localparam int BINFO_W   = 6;
   localparam int AWLEN_LSB = 5;
   localparam int AWLEN_W   = 4;
   localparam int WLAST_BIT = 0;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // AWINFO = {AWID[3:0], AWADDR[31:0], AWLEN[3:0], AWSIZE[2:0], AWBURST[1:0]}
   function automatic logic [AWLEN_W-1:0] aw_len(input logic [AWINFO_W-1:0] info);
      return info[AWLEN_LSB +: AWLEN_W];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request picker: a sole requester wins, a tie goes to the pointer, which moves to the loser on upd.
// With ARB_FIXED_PRIO_EN defined the pointer is removed and M0 always wins a tie (purely combinational).
module rr_arb2
   import axi_wr_arb_pkg::*;
(
`ifndef ARB_FIXED_PRIO_EN
   input  logic       clk,
   input  logic       rst_n,
   input  logic       upd,
   input  logic       upd_gnt,
`endif
   input  logic [1:0] req,
   output logic       pick
);

`ifdef ARB_FIXED_PRIO_EN
   assign pick = (req == 2'b10) ? M1 : M0;
`else
   logic ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= M0;
      end else if (upd) begin
         ptr <= (upd_gnt == M0) ? M1 : M0;
      end
   end

   always_comb begin
      pick = ptr;
      case (req)
         2'b01:   pick = M0;
         2'b10:   pick = M1;
         default: pick = ptr;
      endcase
   end
`endif

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI3 write slave between two masters: AW arbitration with one IDLE cycle of latency, grant held through W and B.
// Ready/valid pass straight through for the granted master only; ARB_FIXED_PRIO_EN selects fixed M0-priority tie-breaking.
module axi_write_arbiter
   import axi_wr_arb_pkg::*;
#(
   parameter int buswidth = 32,
   parameter int WINFO_W  = buswidth + 5
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [2*AWINFO_W-1:0]  M_AWINFO,
   input  logic [1:0]             M_AWVALID,
   output logic [1:0]             M_AWREADY,
   input  logic [2*WINFO_W-1:0]   M_WINFO,
   input  logic [1:0]             M_WVALID,
   output logic [1:0]             M_WREADY,
   output logic [2*BINFO_W-1:0]   M_BINFO,
   output logic [1:0]             M_BVALID,
   input  logic [1:0]             M_BREADY,
   output logic [AWINFO_W-1:0]    S_AWINFO,
   output logic                   S_AWVALID,
   input  logic                   S_AWREADY,
   output logic [WINFO_W-1:0]     S_WINFO,
   output logic                   S_WVALID,
   input  logic                   S_WREADY,
   input  logic [BINFO_W-1:0]     S_BINFO,
   input  logic                   S_BVALID,
   output logic                   S_BREADY,
   output logic                   GNT,
   output logic                   ERR_WLAST
);

   state_t             state;
   logic [AWLEN_W-1:0] awlen_q;
   logic [AWLEN_W-1:0] beat_cnt;
   logic               pick;
   logic               aw_hs;
   logic               w_hs;
   logic               b_hs;
   logic               w_last;

   rr_arb2 u_arb (
`ifndef ARB_FIXED_PRIO_EN
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .upd     (b_hs),
      .upd_gnt (GNT),
`endif
      .req     (M_AWVALID),
      .pick    (pick)
   );

   // Steering depends only on registered state/grant, so no AWVALID->AWREADY path exists.
   always_comb begin
      S_AWINFO  = GNT ? M_AWINFO[2*AWINFO_W-1:AWINFO_W] : M_AWINFO[AWINFO_W-1:0];
      S_WINFO   = GNT ? M_WINFO[2*WINFO_W-1:WINFO_W]    : M_WINFO[WINFO_W-1:0];
      M_BINFO   = {S_BINFO, S_BINFO};
      S_AWVALID = (state == ADDR) && M_AWVALID[GNT];
      S_WVALID  = (state == DATA) && M_WVALID[GNT];
      S_BREADY  = (state == RESP) && M_BREADY[GNT];
      M_AWREADY = 2'b00;
      M_WREADY  = 2'b00;
      M_BVALID  = 2'b00;
      M_AWREADY[GNT] = (state == ADDR) && S_AWREADY;
      M_WREADY[GNT]  = (state == DATA) && S_WREADY;
      M_BVALID[GNT]  = (state == RESP) && S_BVALID;
   end

   assign aw_hs  = S_AWVALID && S_AWREADY;
   assign w_hs   = S_WVALID && S_WREADY;
   assign b_hs   = S_BVALID && S_BREADY;
   assign w_last = S_WINFO[WLAST_BIT];

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state     <= IDLE;
         GNT       <= M0;
         awlen_q   <= '0;
         beat_cnt  <= '0;
         ERR_WLAST <= 1'b0;
      end else begin
         ERR_WLAST <= 1'b0;
         case (state)
            IDLE: begin
               if (|M_AWVALID) begin
                  GNT   <= pick;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  awlen_q  <= aw_len(S_AWINFO);
                  beat_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  // Counter wraps 15->0 so bursts longer than 16 still flag on every aliasing beat.
                  beat_cnt  <= beat_cnt + 4'd1;
                  ERR_WLAST <= w_last ? (beat_cnt != awlen_q) : (beat_cnt == awlen_q);
                  if (w_last) begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (b_hs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
